// File: rtl/video_layer_composite.sv
// Two-stage sprite/background compositor.
// Register writes go to a shadow bank that is copied to the active bank on
// frame_start. Stage 0 issues per-sprite lookup requests with local
// coordinates. Stage 1 picks the lowest-index opaque hit, falls back to the
// background colour, and blanks the output outside the active area.
module video_layer_composite #(
    parameter int NUM_SPRITES = 2,
    parameter int SPRITE_BITS = 5,
    parameter int COLOR_BITS  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [15:0]                           x,
    input  logic [15:0]                           y,
    input  logic                                  visible,
    input  logic                                  frame_start,
    input  logic                                  wr_en,
    input  logic [7:0]                            wr_addr,
    input  logic [15:0]                           wr_data,
    output logic [NUM_SPRITES*SPRITE_BITS-1:0]    spr_x,
    output logic [NUM_SPRITES*SPRITE_BITS-1:0]    spr_y,
    output logic [NUM_SPRITES-1:0]                spr_active,
    input  logic [NUM_SPRITES*3*COLOR_BITS-1:0]   spr_rgb,
    input  logic [NUM_SPRITES-1:0]                spr_opaque,
    output logic [COLOR_BITS-1:0]                 r,
    output logic [COLOR_BITS-1:0]                 g,
    output logic [COLOR_BITS-1:0]                 b
);

    localparam int          RGB_W     = 3 * COLOR_BITS;
    localparam logic [7:0]  BG_ADDR   = 8'(2 * NUM_SPRITES);
    localparam logic [7:0]  MASK_ADDR = 8'(2 * NUM_SPRITES + 1);
    // Sprite side length, widened so pos + size never wraps at 16 bits.
    localparam logic [16:0] SPR_SIZE  = 17'(1 << SPRITE_BITS);

    logic [15:0]            sh_pos_x_r  [NUM_SPRITES];
    logic [15:0]            sh_pos_y_r  [NUM_SPRITES];
    logic [RGB_W-1:0]       sh_bg_r;
    logic [NUM_SPRITES-1:0] sh_mask_r;

    logic [15:0]            sh_pos_x_s  [NUM_SPRITES];
    logic [15:0]            sh_pos_y_s  [NUM_SPRITES];
    logic [RGB_W-1:0]       sh_bg_s;
    logic [NUM_SPRITES-1:0] sh_mask_s;

    logic [15:0]            act_pos_x_r [NUM_SPRITES];
    logic [15:0]            act_pos_y_r [NUM_SPRITES];
    logic [RGB_W-1:0]       act_bg_r;
    logic [NUM_SPRITES-1:0] act_mask_r;

    logic [NUM_SPRITES-1:0]             req_s;
    logic [NUM_SPRITES*SPRITE_BITS-1:0] loc_x_s;
    logic [NUM_SPRITES*SPRITE_BITS-1:0] loc_y_s;
    logic                               vis_d_r;
    logic [RGB_W-1:0]                   sel_rgb_s;

    // Shadow next-state: apply the current write (if any) to the shadow bank.
    always_comb begin
        sh_pos_x_s = sh_pos_x_r;
        sh_pos_y_s = sh_pos_y_r;
        sh_bg_s    = sh_bg_r;
        sh_mask_s  = sh_mask_r;
        if (wr_en) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_addr == 8'(2 * i)) begin
                    sh_pos_x_s[i] = wr_data;
                end else if (wr_addr == 8'(2 * i + 1)) begin
                    sh_pos_y_s[i] = wr_data;
                end else begin
                    sh_pos_x_s[i] = sh_pos_x_s[i];
                end
            end
            if (wr_addr == BG_ADDR) begin
                sh_bg_s = wr_data[RGB_W-1:0];
            end else if (wr_addr == MASK_ADDR) begin
                sh_mask_s = wr_data[NUM_SPRITES-1:0];
            end else begin
                sh_bg_s = sh_bg_r;
            end
        end else begin
            sh_mask_s = sh_mask_r;
        end
    end

    // Shadow bank register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_pos_x_r[i] <= 16'd0;
                sh_pos_y_r[i] <= 16'd0;
            end
            sh_bg_r   <= '0;
            sh_mask_r <= '0;
        end else begin
            sh_pos_x_r <= sh_pos_x_s;
            sh_pos_y_r <= sh_pos_y_s;
            sh_bg_r    <= sh_bg_s;
            sh_mask_r  <= sh_mask_s;
        end
    end

    // Active bank: copies the shadow next-state on frame_start, so a write in
    // the same cycle is committed immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act_pos_x_r[i] <= 16'd0;
                act_pos_y_r[i] <= 16'd0;
            end
            act_bg_r   <= '0;
            act_mask_r <= '0;
        end else if (frame_start) begin
            act_pos_x_r <= sh_pos_x_s;
            act_pos_y_r <= sh_pos_y_s;
            act_bg_r    <= sh_bg_s;
            act_mask_r  <= sh_mask_s;
        end else begin
            act_mask_r  <= act_mask_r;
        end
    end

    // Stage 0 hit test and local coordinates. The low bits of (x - pos)
    // equal the difference of the low bits, so only those are computed.
    always_comb begin
        req_s   = '0;
        loc_x_s = '0;
        loc_y_s = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            req_s[i] = visible && act_mask_r[i]
                    && ({1'b0, x} >= {1'b0, act_pos_x_r[i]})
                    && ({1'b0, x} <  ({1'b0, act_pos_x_r[i]} + SPR_SIZE))
                    && ({1'b0, y} >= {1'b0, act_pos_y_r[i]})
                    && ({1'b0, y} <  ({1'b0, act_pos_y_r[i]} + SPR_SIZE));
            if (req_s[i]) begin
                loc_x_s[i*SPRITE_BITS +: SPRITE_BITS] = x[SPRITE_BITS-1:0] - act_pos_x_r[i][SPRITE_BITS-1:0];
                loc_y_s[i*SPRITE_BITS +: SPRITE_BITS] = y[SPRITE_BITS-1:0] - act_pos_y_r[i][SPRITE_BITS-1:0];
            end else begin
                loc_x_s[i*SPRITE_BITS +: SPRITE_BITS] = '0;
                loc_y_s[i*SPRITE_BITS +: SPRITE_BITS] = '0;
            end
        end
    end

    // Stage 0 registers: lookup requests plus the delayed visible flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr_active <= '0;
            spr_x      <= '0;
            spr_y      <= '0;
            vis_d_r    <= 1'b0;
        end else begin
            spr_active <= req_s;
            spr_x      <= loc_x_s;
            spr_y      <= loc_y_s;
            vis_d_r    <= visible;
        end
    end

    // Stage 1 priority select: scan high to low so the lowest index wins.
    always_comb begin
        sel_rgb_s = act_bg_r;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (spr_active[i] && spr_opaque[i]) begin
                sel_rgb_s = spr_rgb[i*RGB_W +: RGB_W];
            end else begin
                sel_rgb_s = sel_rgb_s;
            end
        end
    end

    // Stage 1 output register, blanked outside the active area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r, g, b} <= '0;
        end else if (!vis_d_r) begin
            {r, g, b} <= '0;
        end else begin
            {r, g, b} <= sel_rgb_s;
        end
    end

endmodule

// File: tb/tb_video_layer_composite.sv
// Directed self-checking bench for video_layer_composite (default parameters).
module tb_video_layer_composite;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x, y;
    logic        visible, frame_start, wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  spr_x, spr_y;
    logic [1:0]  spr_active;
    logic [23:0] spr_rgb;
    logic [1:0]  spr_opaque;
    logic [3:0]  r, g, b;

    int checks   = 0;
    int failures = 0;

    video_layer_composite dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .visible(visible),
        .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .spr_x(spr_x), .spr_y(spr_y),
        .spr_active(spr_active), .spr_rgb(spr_rgb), .spr_opaque(spr_opaque),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        vis;
        logic [1:0]  op;
        logic [1:0]  act;
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drive(input logic [15:0] px, input logic [15:0] py, input logic v);
        x = px; y = py; visible = v;
    endtask

    initial begin
        // sprite0 at (100,50), sprite1 at (90,40), both enabled, bg 0x123
        vecs[0] = '{16'd105, 16'd52,  1'b1, 2'b11, 2'b11, {5'd15, 5'd5},  {5'd12, 5'd2},  12'hF00};
        vecs[1] = '{16'd105, 16'd52,  1'b1, 2'b10, 2'b11, {5'd15, 5'd5},  {5'd12, 5'd2},  12'h0A5};
        vecs[2] = '{16'd105, 16'd52,  1'b1, 2'b00, 2'b11, {5'd15, 5'd5},  {5'd12, 5'd2},  12'h123};
        vecs[3] = '{16'd95,  16'd45,  1'b1, 2'b11, 2'b10, {5'd5,  5'd0},  {5'd5,  5'd0},  12'h0A5};
        vecs[4] = '{16'd10,  16'd10,  1'b1, 2'b11, 2'b00, 10'd0,          10'd0,          12'h123};
        vecs[5] = '{16'd105, 16'd52,  1'b0, 2'b11, 2'b00, 10'd0,          10'd0,          12'h000};
        vecs[6] = '{16'd131, 16'd50,  1'b1, 2'b11, 2'b01, {5'd0,  5'd31}, {5'd0,  5'd0},  12'hF00};
        vecs[7] = '{16'd132, 16'd50,  1'b1, 2'b11, 2'b00, 10'd0,          10'd0,          12'h123};
        vecs[8] = '{16'd100, 16'd81,  1'b1, 2'b01, 2'b01, {5'd0,  5'd0},  {5'd0,  5'd31}, 12'hF00};

        reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 16'd0;
        drive(16'd0, 16'd0, 1'b0);
        spr_rgb = {12'h0A5, 12'hF00}; spr_opaque = 2'b00;
        tick(); tick();
        check("reset_rgb", {20'd0, r, g, b}, 32'd0);
        check("reset_active", {30'd0, spr_active}, 32'd0);
        check("reset_xy", {12'd0, spr_x, spr_y}, 32'd0);
        reset = 1'b0;
        tick();

        // Background only
        write_reg(8'd4, 16'h0123);
        write_reg(8'd5, 16'h0000);
        commit();
        drive(16'd10, 16'd10, 1'b1);
        tick();
        check("bg_lat1", {20'd0, r, g, b}, 32'd0);
        tick();
        check("bg_rgb", {20'd0, r, g, b}, 32'h123);

        // Table-driven composite vectors
        write_reg(8'd0, 16'd100);
        write_reg(8'd1, 16'd50);
        write_reg(8'd2, 16'd90);
        write_reg(8'd3, 16'd40);
        write_reg(8'd5, 16'h0003);
        commit();
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].vis);
            spr_opaque = vecs[i].op;
            tick();
            check($sformatf("v%0d_active", i), {30'd0, spr_active}, {30'd0, vecs[i].act});
            check($sformatf("v%0d_sx", i), {22'd0, spr_x}, {22'd0, vecs[i].sx});
            check($sformatf("v%0d_sy", i), {22'd0, spr_y}, {22'd0, vecs[i].sy});
            tick();
            check($sformatf("v%0d_rgb", i), {20'd0, r, g, b}, {20'd0, vecs[i].rgb});
        end

        // Edges: sprite1 at (65530,0), only sprite1 enabled
        write_reg(8'd2, 16'd65530);
        write_reg(8'd3, 16'd0);
        write_reg(8'd5, 16'h0002);
        commit();
        spr_opaque = 2'b11;
        drive(16'd65535, 16'd0, 1'b1);
        tick();
        check("edge_top_active", {30'd0, spr_active}, 32'd2);
        check("edge_top_sx", {27'd0, spr_x[9:5]}, 32'd5);
        tick();
        check("edge_top_rgb", {20'd0, r, g, b}, 32'h0A5);
        drive(16'd0, 16'd0, 1'b1);
        tick();
        check("edge_nowrap", {30'd0, spr_active}, 32'd0);
        drive(16'd65529, 16'd0, 1'b1);
        tick();
        check("edge_below", {30'd0, spr_active}, 32'd0);

        // Shadow timing: sprite0 only at (100,50)
        write_reg(8'd5, 16'h0001);
        commit();
        drive(16'd105, 16'd52, 1'b1);
        tick();
        check("sh_before", {27'd0, spr_x[4:0]}, 32'd5);
        write_reg(8'd0, 16'd200);
        tick();
        check("sh_midline_active", {30'd0, spr_active}, 32'd1);
        check("sh_midline_sx", {27'd0, spr_x[4:0]}, 32'd5);
        commit();
        tick();
        check("sh_after_commit", {30'd0, spr_active}, 32'd0);
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'd102; frame_start = 1'b1;
        tick();
        wr_en = 1'b0; frame_start = 1'b0;
        tick();
        check("sh_same_cycle_active", {30'd0, spr_active}, 32'd1);
        check("sh_same_cycle_sx", {27'd0, spr_x[4:0]}, 32'd3);
        commit();
        tick();
        check("sh_recommit_sx", {27'd0, spr_x[4:0]}, 32'd3);

        // Reset mid-stream: outputs clear without a clock edge
        tick();
        check("pre_reset_rgb", {20'd0, r, g, b}, 32'hF00);
        reset = 1'b1;
        #1;
        check("async_rgb", {20'd0, r, g, b}, 32'd0);
        check("async_active", {30'd0, spr_active}, 32'd0);
        check("async_xy", {12'd0, spr_x, spr_y}, 32'd0);
        tick();
        reset = 1'b0;
        drive(16'd5, 16'd5, 1'b1);
        tick();
        check("post_reset_mask", {30'd0, spr_active}, 32'd0);
        tick();
        check("post_reset_bg", {20'd0, r, g, b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_layer_composite.md
VIDEO_LAYER_COMPOSITE -- requirements
Module: video_layer_composite

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 2: number of sprite layers, 1..8.
REQ-002 SHALL have parameter SPRITE_BITS, default 5: sprite side is 2^SPRITE_BITS pixels.
REQ-003 SHALL have parameter COLOR_BITS, default 4: bits per colour channel.
REQ-004 SHALL have port clk  input  1: sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port x  input  16: current beam column.
REQ-007 SHALL have port y  input  16: current beam row.
REQ-008 SHALL have port visible  input  1: beam is in the active area.
REQ-009 SHALL have port frame_start  input  1: one-cycle pulse at frame start; commits shadow registers.
REQ-010 SHALL have port wr_en  input  1: register write strobe.
REQ-011 SHALL have port wr_addr  input  8: register address.
REQ-012 SHALL have port wr_data  input  16: register write data.
REQ-013 SHALL have port spr_x  output  NUM_SPRITES*SPRITE_BITS: per-sprite local column; sprite i at slice i.
REQ-014 SHALL have port spr_y  output  NUM_SPRITES*SPRITE_BITS: per-sprite local row.
REQ-015 SHALL have port spr_active  output  NUM_SPRITES: per-sprite lookup request.
REQ-016 SHALL have port spr_rgb  input  NUM_SPRITES*3*COLOR_BITS: per-sprite {r,g,b}; valid one cycle after its request.
REQ-017 SHALL have port spr_opaque  input  NUM_SPRITES: per-sprite opacity; valid one cycle after its request.
REQ-018 SHALL have ports r, g, b  output  COLOR_BITS each: composited pixel.

Function
REQ-019 Register map SHALL be as follows; unmapped addresses are ignored.
- addr 2i: sprite i X position.
- addr 2i+1: sprite i Y position.
- addr 2N: background colour {r,g,b} in the low 3*COLOR_BITS bits.
- addr 2N+1: enable mask in the low NUM_SPRITES bits.
REQ-020 Writes SHALL land in shadow registers; shadow-to-active copy SHALL occur on the cycle frame_start=1.
REQ-021 A write coinciding with frame_start SHALL update the shadow register, and that same write value SHALL be committed to active.
REQ-022 Stage 0 (request) SHALL register spr_active[i] = visible & enable[i] & hit_x & hit_y.
- hit_x: pos_x <= x < pos_x + 2^SPRITE_BITS, evaluated at 17 bits with no 16-bit wrap.
- hit_y: the same test on y against pos_y.
REQ-023 Stage 0 SHALL register spr_x[i] = (x - pos_x)[SPRITE_BITS-1:0] and spr_y[i] likewise; inactive sprites SHALL output 0 coordinates.
REQ-024 Stage 0 SHALL also delay visible and the spr_active vector one cycle into stage 1.
REQ-025 Stage 1 (compose) SHALL select the lowest-index sprite i with delayed active[i] & spr_opaque[i].
- The selected sprite's colour is registered to r, g, b.
- If no sprite is selected, the background colour is registered.
REQ-026 If delayed visible=0, r, g, b SHALL be registered as 0 regardless of sprites or background.
REQ-027 Total latency SHALL be 2 cycles from x/y/visible to r/g/b; throughput SHALL be one pixel per cycle with no stalls.
REQ-028 Active registers used by stage 0 SHALL change only at frame_start; a mid-line write SHALL have no visible effect before the next frame_start.

Reset
REQ-029 While reset=1, the following SHALL be 0 asynchronously: r, g, b, spr_active, spr_x, spr_y, pipeline valid bits.
REQ-030 While reset=1, all shadow and active registers SHALL be 0: enable mask 0, background 0, positions 0.
REQ-031 Reset asserted mid-frame SHALL discard in-flight pixels; after release, the first output SHALL appear 2 cycles after the first visible input.

Verification
REQ-032 Background: reset, write bg=0x123 and mask=0, pulse frame_start, drive visible x=10 y=10 -> after 2 cycles r=1, g=2, b=3.
REQ-033 Single sprite: sprite0 pos (100,50), mask=1, commit, drive x=105 y=52, spr_opaque=1, rgb 0xF00 -> spr_x=5 and spr_y=2 after 1 cycle; r=F g=0 b=0 after 2 cycles.
REQ-034 Priority and transparency: sprites 0 and 1 both at (0,0), mask=3.
- Both opaque -> sprite 0 colour.
- spr_opaque[0]=0 -> sprite 1 colour.
- Both transparent -> background.
REQ-035 Edges: sprite at (65530,0).
- x=65535 -> hit, spr_x=5.
- x=0 -> no hit (no wrap).
- x=pos+32 -> no hit.
REQ-036 Shadow timing: write sprite0 X mid-line -> output unchanged until the frame_start pulse, then the new position is used; a write on the frame_start cycle is committed that same cycle.
REQ-037 Blanking and reset: visible=0 with an opaque hit -> rgb=0 after 2 cycles; assert reset mid-stream -> all outputs 0 immediately, mask 0 after release.
